// File: rtl/bridge_pkg.sv
// Shared definitions for the bridge request arbiter: state encoding, bus
// response codes, the latched-transfer record and small state helpers.
package bridge_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_APB_SETUP  = 3'd1;
    localparam state_t ST_APB_ACCESS = 3'd2;
    localparam state_t ST_AXI_WADDR  = 3'd3;
    localparam state_t ST_AXI_WRESP  = 3'd4;
    localparam state_t ST_AXI_RADDR  = 3'd5;
    localparam state_t ST_AXI_RDATA  = 3'd6;
    localparam state_t ST_DONE       = 3'd7;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bridge_xfer_t;

    // States that wait on a slave response and are therefore subject to abort.
    function automatic logic is_wait_state(input state_t st);
        return (st == ST_APB_ACCESS) || (st == ST_AXI_WRESP) || (st == ST_AXI_RDATA);
    endfunction

    // States in which a requester holds the bus.
    function automatic logic is_busy_state(input state_t st);
        return (st != ST_IDLE) && (st != ST_DONE);
    endfunction

endpackage

// File: rtl/bridge_req_arbiter_rr_arb2.sv
// Two-way round-robin selector: on a tie the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant from the current requests and the last-served index.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/bridge_req_arbiter.sv
// Two-requester bridge arbiter sequencing either an APB or an AXI-lite style
// transfer. Define BRIDGE_ARB_TIMEOUT_EN to abort stalled responses.
module bridge_req_arbiter
    import bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        protocol_select,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        err,
    output logic [15:0] rdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic [15:0] prdata,
    output logic        awvalid,
    output logic        wvalid,
    output logic        bready,
    output logic        arvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [31:0] araddr,
    output logic [31:0] axi_wdata,
    input  logic        awready,
    input  logic        wready,
    input  logic        bvalid,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [1:0]  bresp,
    input  logic [1:0]  rresp,
    input  logic [15:0] axi_rdata
);

    state_t       state_r, state_s;
    logic         win_r, win_s;
    logic         last_r, last_s;
    bridge_xfer_t xfer_r, xfer_s;
    logic         aw_done_r, aw_done_s;
    logic         w_done_r, w_done_s;
    logic [15:0]  cap_rdata_s;
    logic         cap_err_s;
    logic         tmo_hit_s;
    logic [1:0]   arb_gnt_s;

    logic [1:0]   gnt_s, done_s;
    logic         err_s;
    logic [15:0]  rdata_s;
    logic         psel_s, penable_s, pwrite_s;
    logic [31:0]  paddr_s, pwdata_s;
    logic         awvalid_s, wvalid_s, bready_s, arvalid_s, rready_s;
    logic [31:0]  awaddr_s, araddr_s, axi_wdata_s;

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_r),
        .grant (arb_gnt_s)
    );

`ifdef BRIDGE_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] tmo_cnt_r;

    // Count consecutive cycles spent waiting on a slave; restart on any state change.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tmo_cnt_r <= '0;
        end else if (is_wait_state(state_r) && (state_s == state_r)) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    assign tmo_hit_s = is_wait_state(state_r) && (tmo_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state, arbitration and response capture.
    always_comb begin
        state_s     = state_r;
        win_s       = win_r;
        last_s      = last_r;
        xfer_s      = xfer_r;
        aw_done_s   = aw_done_r;
        w_done_s    = w_done_r;
        cap_rdata_s = 16'h0000;
        cap_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    win_s        = arb_gnt_s[1];
                    last_s       = arb_gnt_s[1];
                    xfer_s.we    = arb_gnt_s[1] ? we[1]  : we[0];
                    xfer_s.addr  = arb_gnt_s[1] ? addr1  : addr0;
                    xfer_s.wdata = arb_gnt_s[1] ? wdata1 : wdata0;
                    aw_done_s    = 1'b0;
                    w_done_s     = 1'b0;
                    if (!protocol_select) begin
                        state_s = ST_APB_SETUP;
                    end else if (xfer_s.we) begin
                        state_s = ST_AXI_WADDR;
                    end else begin
                        state_s = ST_AXI_RADDR;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_APB_SETUP: begin
                state_s = ST_APB_ACCESS;
            end
            ST_APB_ACCESS: begin
                if (pready) begin
                    state_s     = ST_DONE;
                    cap_rdata_s = xfer_r.we ? 16'h0000 : prdata;
                end else if (tmo_hit_s) begin
                    state_s   = ST_DONE;
                    cap_err_s = 1'b1;
                end else begin
                    state_s = ST_APB_ACCESS;
                end
            end
            ST_AXI_WADDR: begin
                // Address and data channels retire independently.
                aw_done_s = aw_done_r | (awvalid & awready);
                w_done_s  = w_done_r  | (wvalid & wready);
                if (aw_done_s && w_done_s) begin
                    state_s = ST_AXI_WRESP;
                end else begin
                    state_s = ST_AXI_WADDR;
                end
            end
            ST_AXI_WRESP: begin
                if (bvalid) begin
                    state_s   = ST_DONE;
                    cap_err_s = (bresp != RESP_OKAY);
                end else if (tmo_hit_s) begin
                    state_s   = ST_DONE;
                    cap_err_s = 1'b1;
                end else begin
                    state_s = ST_AXI_WRESP;
                end
            end
            ST_AXI_RADDR: begin
                if (arready) begin
                    state_s = ST_AXI_RDATA;
                end else begin
                    state_s = ST_AXI_RADDR;
                end
            end
            ST_AXI_RDATA: begin
                if (rvalid) begin
                    state_s     = ST_DONE;
                    cap_rdata_s = axi_rdata;
                    cap_err_s   = (rresp != RESP_OKAY);
                end else if (tmo_hit_s) begin
                    state_s   = ST_DONE;
                    cap_err_s = 1'b1;
                end else begin
                    state_s = ST_AXI_RDATA;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so that
    // grant and the first bus phase appear together one cycle after a request.
    always_comb begin
        gnt_s       = is_busy_state(state_s) ? (win_s ? 2'b10 : 2'b01) : 2'b00;
        done_s      = (state_s == ST_DONE) ? (win_s ? 2'b10 : 2'b01) : 2'b00;
        err_s       = (state_s == ST_DONE) ? cap_err_s : 1'b0;
        rdata_s     = (state_s == ST_DONE) ? cap_rdata_s : 16'h0000;
        psel_s      = (state_s == ST_APB_SETUP) || (state_s == ST_APB_ACCESS);
        penable_s   = (state_s == ST_APB_ACCESS);
        pwrite_s    = psel_s & xfer_s.we;
        paddr_s     = psel_s ? xfer_s.addr : 32'h0000_0000;
        pwdata_s    = pwrite_s ? xfer_s.wdata : 32'h0000_0000;
        awvalid_s   = (state_s == ST_AXI_WADDR) && !aw_done_s;
        wvalid_s    = (state_s == ST_AXI_WADDR) && !w_done_s;
        awaddr_s    = (state_s == ST_AXI_WADDR) ? xfer_s.addr : 32'h0000_0000;
        axi_wdata_s = (state_s == ST_AXI_WADDR) ? xfer_s.wdata : 32'h0000_0000;
        bready_s    = (state_s == ST_AXI_WRESP);
        arvalid_s   = (state_s == ST_AXI_RADDR);
        araddr_s    = (state_s == ST_AXI_RADDR) ? xfer_s.addr : 32'h0000_0000;
        rready_s    = (state_s == ST_AXI_RDATA);
    end

    // Control state; reset abandons any in-flight transfer and favours requester 0.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r   <= ST_IDLE;
            win_r     <= 1'b0;
            last_r    <= 1'b1;
            xfer_r    <= '0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            win_r     <= win_s;
            last_r    <= last_s;
            xfer_r    <= xfer_s;
            aw_done_r <= aw_done_s;
            w_done_r  <= w_done_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            gnt       <= 2'b00;
            done      <= 2'b00;
            err       <= 1'b0;
            rdata     <= 16'h0000;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= 32'h0000_0000;
            pwdata    <= 32'h0000_0000;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= 32'h0000_0000;
            araddr    <= 32'h0000_0000;
            axi_wdata <= 32'h0000_0000;
        end else begin
            gnt       <= gnt_s;
            done      <= done_s;
            err       <= err_s;
            rdata     <= rdata_s;
            psel      <= psel_s;
            penable   <= penable_s;
            pwrite    <= pwrite_s;
            paddr     <= paddr_s;
            pwdata    <= pwdata_s;
            awvalid   <= awvalid_s;
            wvalid    <= wvalid_s;
            bready    <= bready_s;
            arvalid   <= arvalid_s;
            rready    <= rready_s;
            awaddr    <= awaddr_s;
            araddr    <= araddr_s;
            axi_wdata <= axi_wdata_s;
        end
    end

endmodule
